// File: rtl/hazard_stall_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline (master) supplies register
// indices and hazard sources; the hazard unit (slave) returns enables, flushes and status.
interface hazard_stall_if;
   logic [4:0]  IFID_rs1;
   logic [4:0]  IFID_rs2;
   logic [4:0]  IDEX_rd;
   logic        IDEX_MemRead;
   logic        branch_taken;
   logic        mem_busy;
   logic        PC_write;
   logic        IFID_write;
   logic        IDEX_bubble;
   logic        IFID_flush;
   logic        IDEX_flush;
   logic        pipe_freeze;
   logic        mem_timeout;
   logic [15:0] load_stall_cnt;
   logic [15:0] flush_cnt;
   logic [15:0] mem_stall_cnt;

   modport master (
      output IFID_rs1, IFID_rs2, IDEX_rd, IDEX_MemRead, branch_taken, mem_busy,
      input  PC_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush, pipe_freeze,
      input  mem_timeout, load_stall_cnt, flush_cnt, mem_stall_cnt
   );

   modport slave (
      input  IFID_rs1, IFID_rs2, IDEX_rd, IDEX_MemRead, branch_taken, mem_busy,
      output PC_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush, pipe_freeze,
      output mem_timeout, load_stall_cnt, flush_cnt, mem_stall_cnt
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for a 5-stage RISC-V pipeline (load-use, branch redirect, memory wait).
// Optional feature: define STALL_COUNTERS_EN to make the three 16-bit stall counters live.
module hazard_stall_unit #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        reset,
   hazard_stall_if.slave bus,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   localparam logic [2:0] RELOAD  = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t     r_state, w_state_nxt;
   logic [2:0] r_remaining, w_remaining_nxt;
   logic [7:0] r_wait_cnt, w_wait_cnt_nxt;
   logic       r_ret_flush, w_ret_flush_nxt;
   logic       r_timeout, w_timeout_nxt;

   logic w_load_use;
   logic w_in_flush;
   logic w_pc_write, w_ifid_write, w_bubble, w_ifid_flush, w_idex_flush, w_freeze;

   assign w_load_use = bus.IDEX_MemRead && (bus.IDEX_rd != 5'd0) &&
                       ((bus.IDEX_rd == bus.IFID_rs1) || (bus.IDEX_rd == bus.IFID_rs2));

   // A MEM_WAIT cycle with mem_busy low behaves like the state it interrupted.
   assign w_in_flush = (r_state == ST_FLUSH) || ((r_state == ST_MEM_WAIT) && r_ret_flush);

   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_wait_cnt_nxt  = r_wait_cnt;
      w_ret_flush_nxt = r_ret_flush;
      w_pc_write      = 1'b1;
      w_ifid_write    = 1'b1;
      w_bubble        = 1'b0;
      w_ifid_flush    = 1'b0;
      w_idex_flush    = 1'b0;
      w_freeze        = 1'b0;

      if (bus.mem_busy) begin
         w_freeze     = 1'b1;
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_state_nxt  = ST_MEM_WAIT;
         if (r_state == ST_MEM_WAIT) begin
            if (r_wait_cnt != 8'hFF) w_wait_cnt_nxt = r_wait_cnt + 8'd1;
         end else begin
            w_wait_cnt_nxt  = 8'd1;
            w_ret_flush_nxt = (r_state == ST_FLUSH);
         end
      end else begin
         w_wait_cnt_nxt  = 8'd0;
         w_ret_flush_nxt = 1'b0;
         if (bus.branch_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
               w_state_nxt     = ST_FLUSH;
               w_remaining_nxt = RELOAD;
            end else begin
               w_state_nxt     = ST_RUN;
               w_remaining_nxt = 3'd0;
            end
         end else if (w_in_flush) begin
            // Load-use is ignored here: the instruction in ID is being discarded.
            w_ifid_flush = 1'b1;
            if (r_remaining <= 3'd1) begin
               w_remaining_nxt = 3'd0;
               w_state_nxt     = ST_RUN;
            end else begin
               w_remaining_nxt = r_remaining - 3'd1;
               w_state_nxt     = ST_FLUSH;
            end
         end else begin
            w_state_nxt = ST_RUN;
            if (w_load_use) begin
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               w_bubble     = 1'b1;
            end
         end
      end

      w_timeout_nxt = r_timeout || (bus.mem_busy && (w_wait_cnt_nxt == TIMEOUT));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_RUN;
         r_remaining <= 3'd0;
         r_wait_cnt  <= 8'd0;
         r_ret_flush <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_ret_flush <= w_ret_flush_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   // Control outputs fall back to the no-hazard defaults while reset is held.
   assign bus.PC_write    = reset ? w_pc_write   : 1'b1;
   assign bus.IFID_write  = reset ? w_ifid_write : 1'b1;
   assign bus.IDEX_bubble = reset & w_bubble;
   assign bus.IFID_flush  = reset & w_ifid_flush;
   assign bus.IDEX_flush  = reset & w_idex_flush;
   assign bus.pipe_freeze = reset & w_freeze;
   assign bus.mem_timeout = reset & r_timeout;
   assign o_dbg_state     = r_state;

`ifdef STALL_COUNTERS_EN
   logic [15:0] r_load_stall_cnt, r_flush_cnt, r_mem_stall_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_load_stall_cnt <= 16'h0000;
         r_flush_cnt      <= 16'h0000;
         r_mem_stall_cnt  <= 16'h0000;
      end else begin
         if (w_bubble && (r_load_stall_cnt != 16'hFFFF))
            r_load_stall_cnt <= r_load_stall_cnt + 16'd1;
         if (!bus.mem_busy && bus.branch_taken && (r_flush_cnt != 16'hFFFF))
            r_flush_cnt <= r_flush_cnt + 16'd1;
         if (w_freeze && (r_mem_stall_cnt != 16'hFFFF))
            r_mem_stall_cnt <= r_mem_stall_cnt + 16'd1;
      end
   end

   assign bus.load_stall_cnt = r_load_stall_cnt;
   assign bus.flush_cnt      = r_flush_cnt;
   assign bus.mem_stall_cnt  = r_mem_stall_cnt;
`else
   assign bus.load_stall_cnt = 16'h0000;
   assign bus.flush_cnt      = 16'h0000;
   assign bus.mem_stall_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (FLUSH_CYCLES=3, MEM_TIMEOUT=4): the driver pushes
// hand-computed expectations per cycle, the monitor pops and compares mid-cycle.
module tb_hazard_stall_unit;

   typedef struct packed {
      logic [6:0]  ctrl;
      logic        chk_st;
      logic [1:0]  st;
      logic        chk_cnt;
      logic [15:0] lc;
      logic [15:0] fc;
      logic [15:0] mc;
   } exp_t;

   localparam int W = $bits(exp_t);

   // ctrl = {PC_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush, pipe_freeze, mem_timeout}
   localparam logic [6:0] C_DEF = 7'b1100000;
   localparam logic [6:0] C_LU  = 7'b0010000;
   localparam logic [6:0] C_BR  = 7'b1101100;
   localparam logic [6:0] C_FL  = 7'b1101000;
   localparam logic [6:0] C_FRZ = 7'b0000010;
   localparam logic [6:0] C_TO  = 7'b0000001;
   localparam logic [1:0] S_RUN = 2'd0;
   localparam logic [1:0] S_FL  = 2'd1;
   localparam logic [1:0] S_MW  = 2'd2;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;

   hazard_stall_if hif ();

   hazard_stall_unit #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (hif),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      reset            = 1'b0;
      hif.IFID_rs1     = 5'd0;
      hif.IFID_rs2     = 5'd0;
      hif.IDEX_rd      = 5'd0;
      hif.IDEX_MemRead = 1'b0;
      hif.branch_taken = 1'b0;
      hif.mem_busy     = 1'b0;
   end

   logic [W-1:0] exp_q[$];
   int n_total = 0;
   int n_pass  = 0;
   int n_pop   = 0;

   function automatic logic [15:0] ce(input logic [15:0] v);
`ifdef STALL_COUNTERS_EN
      return v;
`else
      return 16'h0000 & v;
`endif
   endfunction

   // driver
   task automatic step(input logic rn, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic bt, input logic mb,
                       input logic [6:0] ctrl, input logic cs, input logic [1:0] st,
                       input logic cc, input logic [15:0] lc, input logic [15:0] fc,
                       input logic [15:0] mc);
      exp_t e;
      @(posedge clk);
      #1;
      reset            = rn;
      hif.IFID_rs1     = rs1;
      hif.IFID_rs2     = rs2;
      hif.IDEX_rd      = rd;
      hif.IDEX_MemRead = mr;
      hif.branch_taken = bt;
      hif.mem_busy     = mb;
      e.ctrl    = ctrl;
      e.chk_st  = cs;
      e.st      = st;
      e.chk_cnt = cc;
      e.lc      = ce(lc);
      e.fc      = ce(fc);
      e.mc      = ce(mc);
      exp_q.push_back(W'(e));
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t        e;
         logic [6:0]  got_ctrl;
         logic [47:0] got_cnt;
         e = exp_t'(exp_q.pop_front());
         n_pop++;
         got_ctrl = {hif.PC_write, hif.IFID_write, hif.IDEX_bubble, hif.IFID_flush,
                     hif.IDEX_flush, hif.pipe_freeze, hif.mem_timeout};
         n_total++;
         if (got_ctrl === e.ctrl) n_pass++;
         else $display("FAIL ctrl step %0d: got %b required %b", n_pop, got_ctrl, e.ctrl);
         if (e.chk_st) begin
            n_total++;
            if (dbg_state === e.st) n_pass++;
            else $display("FAIL state step %0d: got %0d required %0d", n_pop, dbg_state, e.st);
         end
         if (e.chk_cnt) begin
            got_cnt = {hif.load_stall_cnt, hif.flush_cnt, hif.mem_stall_cnt};
            n_total++;
            if (got_cnt === {e.lc, e.fc, e.mc}) n_pass++;
            else $display("FAIL counters step %0d: got %h/%h/%h required %h/%h/%h", n_pop,
                          hif.load_stall_cnt, hif.flush_cnt, hif.mem_stall_cnt, e.lc, e.fc, e.mc);
         end
      end
   end

   initial begin
      //    rn rs1 rs2 rd mr bt mb  ctrl          cs st    cc lc fc mc
      step(0, 0, 0, 0, 0, 0, 0, C_DEF,         0, S_RUN, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, C_DEF,         1, S_RUN, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, C_DEF,         1, S_RUN, 0, 0, 0, 0);
      // load-use on rs1, then the bubbled slot
      step(1, 5, 0, 5, 1, 0, 0, C_LU,          1, S_RUN, 0, 0, 0, 0);
      step(1, 5, 0, 0, 0, 0, 0, C_DEF,         1, S_RUN, 1, 1, 0, 0);
      // rd=x0 never stalls
      step(1, 0, 0, 0, 1, 0, 0, C_DEF,         1, S_RUN, 1, 1, 0, 0);
      // load-use on rs2, then a non-matching load
      step(1, 1, 7, 7, 1, 0, 0, C_LU,          1, S_RUN, 0, 0, 0, 0);
      step(1, 3, 4, 7, 1, 0, 0, C_DEF,         1, S_RUN, 1, 2, 0, 0);
      // taken branch: 3 IF/ID flush cycles, load-use ignored while flushing
      step(1, 0, 0, 0, 0, 1, 0, C_BR,          1, S_RUN, 0, 0, 0, 0);
      step(1, 5, 0, 5, 1, 0, 0, C_FL,          1, S_FL,  1, 2, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, C_FL,          1, S_FL,  0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, C_DEF,         1, S_RUN, 1, 2, 1, 0);
      // busy + branch + load-use: freeze only, branch fires when busy drops
      step(1, 5, 0, 5, 1, 1, 1, C_FRZ,         1, S_RUN, 0, 0, 0, 0);
      step(1, 5, 0, 5, 1, 1, 0, C_BR,          1, S_MW,  1, 2, 1, 1);
      step(1, 0, 0, 0, 0, 0, 0, C_FL,          1, S_FL,  1, 2, 2, 1);
      // busy inside FLUSH holds remaining, resumes FLUSH afterwards
      step(1, 0, 0, 0, 0, 0, 1, C_FRZ,         1, S_FL,  1, 2, 2, 1);
      step(1, 0, 0, 0, 0, 0, 0, C_FL,          1, S_MW,  0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, C_DEF,         1, S_RUN, 1, 2, 2, 2);
      // branch inside FLUSH reloads the window
      step(1, 0, 0, 0, 0, 1, 0, C_BR,          1, S_RUN, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, C_FL,          1, S_FL,  0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1, 0, C_BR,          1, S_FL,  1, 2, 3, 2);
      step(1, 0, 0, 0, 0, 0, 0, C_FL,          1, S_FL,  0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, C_FL,          1, S_FL,  0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, C_DEF,         1, S_RUN, 1, 2, 4, 2);
      // six busy cycles: timeout flag appears after the 4th and is sticky
      step(1, 0, 0, 0, 0, 0, 1, C_FRZ,         1, S_RUN, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, C_FRZ,         1, S_MW,  1, 2, 4, 3);
      step(1, 0, 0, 0, 0, 0, 1, C_FRZ,         1, S_MW,  0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, C_FRZ,         1, S_MW,  0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, C_FRZ | C_TO,  1, S_MW,  0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, C_FRZ | C_TO,  1, S_MW,  1, 2, 4, 7);
      step(1, 0, 0, 0, 0, 0, 0, C_DEF | C_TO,  1, S_MW,  0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, C_DEF | C_TO,  1, S_RUN, 1, 2, 4, 8);
      step(1, 5, 0, 5, 1, 0, 0, C_LU | C_TO,   1, S_RUN, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1, 0, C_BR | C_TO,   1, S_RUN, 1, 3, 4, 8);
      step(1, 0, 0, 0, 0, 0, 0, C_FL | C_TO,   1, S_FL,  0, 0, 0, 0);
      // reset mid-FLUSH: defaults immediately, state/counters/flag cleared at the edge
      step(0, 0, 0, 0, 0, 0, 0, C_DEF,         1, S_FL,  1, 3, 5, 8);
      step(0, 0, 0, 0, 0, 0, 0, C_DEF,         1, S_RUN, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, C_DEF,         1, S_RUN, 1, 0, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
